// File: rtl/rr_stream_mux.sv
// rtl/rr_stream_mux.sv - round-robin N-to-1 stream multiplexer with a registered output stage
// Optional packet lock (hold grant until in_last) is enabled by defining RR_STREAM_MUX_PKT_LOCK_EN.
module rr_stream_mux #(
  parameter int  N     = 4,
  parameter int  WIDTH = 8,
  localparam int SW    = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
  input  logic [N-1:0]       in_last,
`endif
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SW-1:0]    ptr;
  logic             load_en;
  logic             grant_found;
  logic [SW-1:0]    grant_idx;
  logic [SW-1:0]    cand_idx;
  logic [WIDTH-1:0] chan_data [N];
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
  logic             lock_q;
`endif

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  assign load_en = !out_valid || out_ready;

  // Search starts one past the last grant so every waiting channel is reached within N grants.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int k = 1; k <= N; k++) begin
      cand_idx = SW'((int'(ptr) + k) % N);
      if (!grant_found && in_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    // Mid-packet the last granted channel (ptr) is the only candidate.
    if (lock_q) begin
      grant_found = in_valid[ptr];
      grant_idx   = ptr;
    end
`endif
  end

  always_comb begin
    in_ready = '0;
    if (rst_n && load_en && grant_found) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= SW'(N - 1);
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
      lock_q    <= 1'b0;
`endif
    end else if (load_en) begin
      if (grant_found) begin
        out_valid <= 1'b1;
        out_data  <= chan_data[grant_idx];
        out_sel   <= grant_idx;
        ptr       <= grant_idx;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
        lock_q    <= !in_last[grant_idx];
`endif
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb/tb_rr_stream_mux.sv - self-checking bench for rr_stream_mux
// Vector table, directed corner sequences and a randomized run against a queue-based model.
module tb_rr_stream_mux;
  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int SW    = 2;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [N-1:0]       pkt_last;
  logic [WIDTH-1:0]   out_data;
  logic [SW-1:0]      out_sel;
  logic               out_valid;
  logic               out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_stream_mux #(.N(N), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    .in_last   (pkt_last),
`endif
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: output register as a queue of at most one beat, plus last-grant pointer.
  typedef struct {
    int               ch;
    logic [WIDTH-1:0] d;
  } beat_t;
  beat_t q[$];
  int    mptr;
  bit    mlock;

  function automatic int model_winner(input logic [N-1:0] iv, input logic ordy);
    int g;
    g = -1;
    if (q.size() != 0 && !ordy) return -1;
    if (LOCK && mlock) return iv[mptr] ? mptr : -1;
    for (int k = 1; k <= N; k++)
      if (g < 0 && iv[(mptr + k) % N]) g = (mptr + k) % N;
    return g;
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = '1;
    out_ready = 1'b1;
    pkt_last  = '1;
    #1;
    chk("rst_ov", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sel", out_sel, 0);
    chk("rst_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_ready", in_ready, 0);
    chk("rst_hold_ov", out_valid, 0);
    rst_n    = 1'b1;
    in_valid = '0;
    q.delete();
    mptr  = N - 1;
    mlock = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0]     iv;
    logic             ordy;
    logic [N-1:0]     rdy;
    logic             ov;
    logic [SW-1:0]    sel;
    logic [WIDTH-1:0] d;
  } vec_t;
  vec_t tbl[12];

  logic [N-1:0] exp_r;
  int           g;
  int           waitc[N];
  int           maxw;
  beat_t        b;

  initial begin
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h00};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h22};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h33};
    tbl[4]  = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h00};
    tbl[5]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h33};
    tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 8'h33};
    tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 8'h33};
    tbl[8]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 8'h22};
    tbl[9]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h22};
    tbl[10] = '{4'b0010, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h22};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 8'h22};

    in_data = 32'h3322_1100;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_ov", i), out_valid, tbl[i].ov);
      chk($sformatf("tbl%0d_sel", i), out_sel, tbl[i].sel);
      chk($sformatf("tbl%0d_data", i), out_data, tbl[i].d);
    end

    // Stall with a held beat from channel 2.
    in_data = 32'h00A5_0000;
    do_reset();
    in_valid  = 4'b0100;
    out_ready = 1'b0;
    #1;
    chk("stall_first_ready", in_ready, 4'b0100);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", in_ready, 0);
      chk("stall_ov", out_valid, 1);
      chk("stall_data", out_data, 8'hA5);
      chk("stall_sel", out_sel, 2);
      @(posedge clk);
      #1;
    end
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    #1;
    chk("stall_deliver_ov", out_valid, 1);
    chk("stall_deliver_data", out_data, 8'hA5);
    @(posedge clk);
    #1;
    chk("stall_after_ov", out_valid, 0);

    // Reset pulsed mid-stream.
    in_data = 32'h3322_1100;
    do_reset();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_pre_ov", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ov", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_rel_ready", in_ready, 4'b0001);
    @(posedge clk);
    #1;
    chk("midrst_rel_sel", out_sel, 0);
    chk("midrst_rel_ov", out_valid, 1);

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    // Channel 1 sends a three-beat packet while channel 0 waits.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = (i == 0) ? 4'b0010 : 4'b0011;
      pkt_last = (i == 2) ? 4'b0010 : 4'b0000;
      #1;
      chk($sformatf("lock%0d_ready", i), in_ready, (i == 3) ? 4'b0001 : 4'b0010);
      @(posedge clk);
      #1;
      chk($sformatf("lock%0d_sel", i), out_sel, (i == 3) ? 0 : 1);
    end
`endif

    // Randomized run against the model.
    do_reset();
    in_valid = '0;
    maxw     = 0;
    for (int c = 0; c < N; c++) waitc[c] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(3) == 0) in_valid[c] = ~in_valid[c];
      in_data   = $urandom;
      out_ready = ($urandom_range(3) != 0);
      pkt_last  = N'($urandom);
      #1;
      g     = model_winner(in_valid, out_ready);
      exp_r = (g < 0) ? '0 : (N'(1) << g);
      chk("rnd_ready", in_ready, exp_r);
      chk("rnd_ov", out_valid, q.size() != 0);
      if (q.size() != 0 && out_ready) begin
        b = q.pop_front();
        chk("rnd_sel", out_sel, b.ch);
        chk("rnd_data", out_data, b.d);
      end
      if (g >= 0) begin
        q.push_back('{g, in_data[g*WIDTH +: WIDTH]});
        mptr  = g;
        mlock = !pkt_last[g];
      end
      for (int c = 0; c < N; c++) begin
        if (!in_valid[c] || in_ready[c]) waitc[c] = 0;
        else if (|in_ready) waitc[c]++;
        if (waitc[c] > maxw) maxw = waitc[c];
      end
      @(posedge clk);
      #1;
    end
`ifndef RR_STREAM_MUX_PKT_LOCK_EN
    chk("rnd_starvation_bound", (maxw <= N - 1), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
